hci_hwpe_order_ctrl: RTL and testbench

HCI_HWPE_ORDER_CTRL -- requirements
Module: hci_hwpe_order_ctrl

---
 rtl/hci_hwpe_order_ctrl.sv | 157 +++++++++++++++
 tb/tb_hci_hwpe_order_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_hwpe_order_ctrl.sv
// hci_hwpe_order_ctrl
//
// Purpose: keeps the channel rotation (order) for the TCDM reorder datapath
// consistent with the responses still in flight. A wide request whose word
// index modulo NB_CHAN differs from the rotation currently in use is held
// back until every outstanding transaction has returned its r_valid.
// Requests that keep the same rotation are forwarded at full rate, up to
// MAX_OUTSTANDING transactions in flight.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   clear_i        synchronous clear, restores reset state
//   req_i, addr_i  upstream request and byte address (held until gnt_o)
//   gnt_o          upstream grant (req_o & gnt_i)
//   req_o          request forwarded to the reorder datapath
//   gnt_i          datapath grant
//   r_valid_i      datapath response valid, one per granted transaction
//   order_o        channel rotation driven to the datapath
//   busy_o         high when not IDLE
//   outstanding_o  registered outstanding-transaction count
//   err_o          sticky flag: r_valid_i seen with nothing outstanding
module hci_hwpe_order_ctrl #(
    parameter int NB_CHAN         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clear_i,
    input  logic                                   req_i,
    input  logic [ADDR_WIDTH-1:0]                  addr_i,
    output logic                                   gnt_o,
    output logic                                   req_o,
    input  logic                                   gnt_i,
    input  logic                                   r_valid_i,
    output logic [$clog2(NB_CHAN)-1:0]             order_o,
    output logic                                   busy_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int OW = $clog2(NB_CHAN);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [OW-1:0] order_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          err_reg;
    logic          err_set;

    logic [OW-1:0] req_order;
    logic          full;
    logic          req_int;
    logic          handshake;

    assign req_order = addr_i[2 +: OW];

    // The full check uses only the registered count so that r_valid_i has
    // no combinational path into req_o.
    assign full = (count_reg == CW'(MAX_OUTSTANDING));

    always_comb begin
        order_o = order_reg;
        req_int = 1'b0;
        case (state_reg)
            IDLE: begin
                order_o = req_order;
                req_int = req_i;
            end
            ACTIVE: begin
                req_int = req_i && (req_order == order_reg) && !full;
            end
            default: begin
                req_int = 1'b0;
            end
        endcase
    end

    // Gating with rst_ni keeps the datapath quiet for the whole reset pulse,
    // including the part of the cycle before the asynchronous clear lands.
    assign req_o     = req_int & rst_ni;
    assign gnt_o     = req_o & gnt_i;
    assign handshake = gnt_o;

    always_comb begin
        count_next = count_reg;
        err_set    = 1'b0;
        if (handshake && !r_valid_i) begin
            count_next = count_reg + CW'(1);
        end else if (!handshake && r_valid_i) begin
            if (count_reg == '0) begin
                err_set = 1'b1;
            end else begin
                count_next = count_reg - CW'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (handshake) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (req_i && (req_order != order_reg) && (count_next != '0)) begin
                    state_next = DRAIN;
                end else if (count_next == '0) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (count_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            order_reg <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else if (clear_i) begin
            state_reg <= IDLE;
            order_reg <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (handshake) begin
                order_reg <= order_o;
            end
            if (err_set) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign busy_o        = (state_reg != IDLE);
    assign outstanding_o = count_reg;
    assign err_o         = err_reg;

endmodule

// File: tb/tb_hci_hwpe_order_ctrl.sv
// Testbench for hci_hwpe_order_ctrl (NB_CHAN=4, MAX_OUTSTANDING=4).
// Directed stimulus pushes the expected order of every grant it expects into
// a queue; a monitor pops and compares on each cycle where gnt_o is high.
// Status outputs are checked directly by the stimulus process.
module tb_hci_hwpe_order_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        req_i;
    logic [31:0] addr_i;
    logic        gnt_o;
    logic        req_o;
    logic        gnt_i;
    logic        r_valid_i;
    logic [1:0]  order_o;
    logic        busy_o;
    logic [2:0]  outstanding_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;
    logic [1:0] exp_q[$];

    hci_hwpe_order_ctrl #(
        .NB_CHAN(4),
        .ADDR_WIDTH(32),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .clear_i(clear_i),
        .req_i(req_i),
        .addr_i(addr_i),
        .gnt_o(gnt_o),
        .req_o(req_o),
        .gnt_i(gnt_i),
        .r_valid_i(r_valid_i),
        .order_o(order_o),
        .busy_o(busy_o),
        .outstanding_o(outstanding_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant scoreboard monitor.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (gnt_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", {30'd0, order_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_order", {30'd0, order_o}, {30'd0, e});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; req_i = 1'b1; addr_i = 32'h8;
        gnt_i = 1'b1; r_valid_i = 1'b0;
        #2;
        chk("rst_req_o", req_o, 0);
        chk("rst_gnt_o", gnt_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_err", err_o, 0);
        req_i = 1'b0;
        #10 rst_ni = 1'b1;

        // Single request from IDLE at addr 0x08.
        tick();
        req_i = 1; addr_i = 32'h08; gnt_i = 1; exp_q.push_back(2'd2);
        #2;
        chk("t1_req_o", req_o, 1);
        chk("t1_order_o", order_o, 2);
        chk("t1_gnt_o", gnt_o, 1);
        tick();
        req_i = 0; r_valid_i = 1;
        #2;
        chk("t1_busy", busy_o, 1);
        chk("t1_outstanding", outstanding_o, 1);
        tick();
        r_valid_i = 0;
        #2;
        chk("t1_idle", busy_o, 0);

        // Back-to-back stream with constant order 2.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            if (i < 4) begin
                req_i = 1; addr_i = 32'h08 + 32'(16 * i); exp_q.push_back(2'd2);
            end else begin
                req_i = 0;
            end
            r_valid_i = (i > 0);
            #2;
            chk("t2_count_le1", {31'd0, outstanding_o <= 3'd1}, 1);
        end
        tick();
        r_valid_i = 0;
        #2;
        chk("t2_idle", busy_o, 0);
        chk("t2_outstanding", outstanding_o, 0);

        // Order change forces a drain.
        tick();
        req_i = 1; addr_i = 32'h08; exp_q.push_back(2'd2);
        tick();
        addr_i = 32'h04;
        #2;
        chk("t3_stall_req_o", req_o, 0);
        tick();
        r_valid_i = 1;
        #2;
        chk("t3_drain_busy", busy_o, 1);
        chk("t3_drain_req_o", req_o, 0);
        tick();
        r_valid_i = 0;
        #1;
        chk("t3_idle_busy", busy_o, 0);
        chk("t3_idle_order", order_o, 1);
        chk("t3_idle_req_o", req_o, 1);
        exp_q.push_back(2'd1);
        tick();
        req_i = 0; r_valid_i = 1;
        tick();
        r_valid_i = 0;
        #2;
        chk("t3_end_idle", busy_o, 0);

        // Outstanding limit with responses withheld.
        for (int i = 0; i < 4; i++) begin
            tick();
            req_i = 1; addr_i = 32'h0C; exp_q.push_back(2'd3);
        end
        tick();
        r_valid_i = 1;
        #2;
        chk("t4_full_count", outstanding_o, 4);
        chk("t4_full_req_o", req_o, 0);
        tick();
        r_valid_i = 0; exp_q.push_back(2'd3);
        #2;
        chk("t4_fifth_req_o", req_o, 1);
        tick();
        req_i = 0; r_valid_i = 1;
        for (int i = 0; i < 3; i++) tick();
        tick();
        r_valid_i = 0;
        #2;
        chk("t4_idle", busy_o, 0);
        chk("t4_outstanding", outstanding_o, 0);

        // Simultaneous handshake and response; underflow.
        tick();
        req_i = 1; addr_i = 32'h00; exp_q.push_back(2'd0);
        tick();
        exp_q.push_back(2'd0);
        tick();
        r_valid_i = 1; exp_q.push_back(2'd0);
        tick();
        req_i = 0;
        #2;
        chk("t5_count_stays2", outstanding_o, 2);
        tick();
        tick();
        #2;
        chk("t5_drained", outstanding_o, 0);
        tick();
        r_valid_i = 0;
        #2;
        chk("t5_err", err_o, 1);
        chk("t5_count0", outstanding_o, 0);
        tick();
        #2;
        chk("t5_err_sticky", err_o, 1);

        // Clear while draining with three outstanding.
        tick();
        req_i = 1; addr_i = 32'h00; exp_q.push_back(2'd0);
        tick();
        exp_q.push_back(2'd0);
        tick();
        exp_q.push_back(2'd0);
        tick();
        addr_i = 32'h04;
        tick();
        #2;
        chk("t6_drain_busy", busy_o, 1);
        chk("t6_drain_count", outstanding_o, 3);
        clear_i = 1; r_valid_i = 1;
        tick();
        clear_i = 0; r_valid_i = 0; gnt_i = 0; addr_i = 32'h0C;
        #2;
        chk("t6_clr_busy", busy_o, 0);
        chk("t6_clr_count", outstanding_o, 0);
        chk("t6_clr_err", err_o, 0);
        chk("t6_clr_order", order_o, 3);
        chk("t6_clr_req_o", req_o, 1);
        addr_i = 32'h08;
        #1;
        chk("t6_order_follows", order_o, 2);

        // Asynchronous reset mid-cycle.
        tick();
        gnt_i = 1; exp_q.push_back(2'd2);
        tick();
        gnt_i = 0;
        #2;
        chk("t7_active_req_o", req_o, 1);
        rst_ni = 0;
        #1;
        chk("t7_rst_req_o", req_o, 0);
        chk("t7_rst_busy", busy_o, 0);
        chk("t7_rst_count", outstanding_o, 0);
        #3 rst_ni = 1;
        req_i = 0;
        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
